// File: rtl/store_checker.sv
// Store-bus self-check monitor: compares core stores, in order, against an expected table.
// Optional macro STORE_CHECKER_CAPTURE_EN builds registers that latch the first mismatching store.
module store_checker #(
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter int                NUM_CHECKS     = 1,
  parameter int                IGNORE_EN      = 1,
  parameter logic [ADDR_W-1:0] IGNORE_ADDR    = ADDR_W'(96),
  parameter int                TIMEOUT_CYCLES = 25,
  parameter int                CNT_W          = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         mem_write,
  input  logic [ADDR_W-1:0]            data_adr,
  input  logic [DATA_W-1:0]            write_data,
  input  logic [NUM_CHECKS*ADDR_W-1:0] exp_addr,
  input  logic [NUM_CHECKS*DATA_W-1:0] exp_data,
  output logic [2:0]                   state,
  output logic                         done,
  output logic                         pass,
  output logic                         fail,
  output logic [CNT_W-1:0]             match_cnt,
  output logic [CNT_W-1:0]             ignore_cnt,
  output logic [CNT_W-1:0]             cycle_cnt,
  output logic [ADDR_W-1:0]            fail_addr,
  output logic [DATA_W-1:0]            fail_data
);

  localparam int IDX_W = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHECKS - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_PASS    = 3'd2,
    S_FAIL    = 3'd3,
    S_TIMEOUT = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
  logic [CNT_W-1:0] ignore_cnt_q, ignore_cnt_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;

  logic in_run, restart, ignore_hit, match_hit, last_hit;
  logic store_cmp, pass_ev, fail_ev, timeout_ev;

  assign in_run     = (state_q == S_RUN);
  assign restart    = start && !in_run;
  assign ignore_hit = (IGNORE_EN != 0) && (data_adr == IGNORE_ADDR);
  assign match_hit  = (data_adr == exp_addr[idx_q*ADDR_W +: ADDR_W]) &&
                      (write_data == exp_data[idx_q*DATA_W +: DATA_W]);
  assign last_hit   = (idx_q == LAST_IDX);
  assign store_cmp  = in_run && mem_write && !ignore_hit;
  assign pass_ev    = store_cmp && match_hit && last_hit;
  assign fail_ev    = store_cmp && !match_hit;
  // A store verdict on the expiry edge wins over the timeout.
  assign timeout_ev = (TIMEOUT_CYCLES != 0) && in_run && (cycle_cnt_q == TO_LAST) &&
                      !pass_ev && !fail_ev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN: begin
        if (pass_ev)         state_d = S_PASS;
        else if (fail_ev)    state_d = S_FAIL;
        else if (timeout_ev) state_d = S_TIMEOUT;
      end
      default: if (start) state_d = S_RUN;
    endcase
  end

  always_comb begin
    state = state_q;
    pass  = (state_q == S_PASS);
    fail  = (state_q == S_FAIL) || (state_q == S_TIMEOUT);
    done  = pass || fail;
  end

  always_comb begin
    idx_d        = idx_q;
    match_cnt_d  = match_cnt_q;
    ignore_cnt_d = ignore_cnt_q;
    cycle_cnt_d  = cycle_cnt_q;
    if (restart) begin
      idx_d        = '0;
      match_cnt_d  = '0;
      ignore_cnt_d = '0;
      cycle_cnt_d  = '0;
    end else if (in_run) begin
      if (!timeout_ev && cycle_cnt_q != '1) cycle_cnt_d = cycle_cnt_q + 1'b1;
      if (mem_write && ignore_hit) begin
        if (ignore_cnt_q != '1) ignore_cnt_d = ignore_cnt_q + 1'b1;
      end else if (store_cmp && match_hit) begin
        if (match_cnt_q != '1) match_cnt_d = match_cnt_q + 1'b1;
        if (!last_hit) idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q        <= '0;
      match_cnt_q  <= '0;
      ignore_cnt_q <= '0;
      cycle_cnt_q  <= '0;
    end else begin
      idx_q        <= idx_d;
      match_cnt_q  <= match_cnt_d;
      ignore_cnt_q <= ignore_cnt_d;
      cycle_cnt_q  <= cycle_cnt_d;
    end
  end

  assign match_cnt  = match_cnt_q;
  assign ignore_cnt = ignore_cnt_q;
  assign cycle_cnt  = cycle_cnt_q;

`ifdef STORE_CHECKER_CAPTURE_EN
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic [DATA_W-1:0] fail_data_q, fail_data_d;

  always_comb begin
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    if (restart) begin
      fail_addr_d = '0;
      fail_data_d = '0;
    end else if (fail_ev) begin
      fail_addr_d = data_adr;
      fail_data_d = write_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fail_addr_q <= '0;
      fail_data_q <= '0;
    end else begin
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
    end
  end

  assign fail_addr = fail_addr_q;
  assign fail_data = fail_data_q;
`else
  assign fail_addr = '0;
  assign fail_data = '0;
`endif

endmodule

// File: tb/tb_store_checker.sv
// Directed bench for store_checker: default, 3-entry and short-timeout instances share one store bus.
`timescale 1ns/1ps
module tb_store_checker;

  logic        clock;
  logic        reset;
  logic        start;
  logic        memWrite;
  logic [31:0] dataAdr;
  logic [31:0] writeData;

  int checkCount;
  int failCount;

  // Expected tables: A and C hold a single (100,25) pair, B holds three pairs.
  logic [31:0] expAddrA, expDataA;
  logic [95:0] expAddrB, expDataB;

  logic [2:0]  stateA, stateB, stateC;
  logic        doneA, passA, failA, doneB, passB, failB, doneC, passC, failC;
  logic [15:0] matchA, ignoreA, cycleA, matchB, ignoreB, cycleB, matchC, ignoreC, cycleC;
  logic [31:0] failAddrA, failDataA, failAddrB, failDataB, failAddrC, failDataC;

  logic [31:0] expFailAddr, expFailData;

  store_checker dutA (
    .clk(clock), .reset(reset), .start(start), .mem_write(memWrite),
    .data_adr(dataAdr), .write_data(writeData), .exp_addr(expAddrA), .exp_data(expDataA),
    .state(stateA), .done(doneA), .pass(passA), .fail(failA),
    .match_cnt(matchA), .ignore_cnt(ignoreA), .cycle_cnt(cycleA),
    .fail_addr(failAddrA), .fail_data(failDataA)
  );

  store_checker #(.NUM_CHECKS(3)) dutB (
    .clk(clock), .reset(reset), .start(start), .mem_write(memWrite),
    .data_adr(dataAdr), .write_data(writeData), .exp_addr(expAddrB), .exp_data(expDataB),
    .state(stateB), .done(doneB), .pass(passB), .fail(failB),
    .match_cnt(matchB), .ignore_cnt(ignoreB), .cycle_cnt(cycleB),
    .fail_addr(failAddrB), .fail_data(failDataB)
  );

  store_checker #(.TIMEOUT_CYCLES(2)) dutC (
    .clk(clock), .reset(reset), .start(start), .mem_write(memWrite),
    .data_adr(dataAdr), .write_data(writeData), .exp_addr(expAddrA), .exp_data(expDataA),
    .state(stateC), .done(doneC), .pass(passC), .fail(failC),
    .match_cnt(matchC), .ignore_cnt(ignoreC), .cycle_cnt(cycleC),
    .fail_addr(failAddrC), .fail_data(failDataC)
  );

  // Free-running clock; inputs change and outputs are sampled on the falling edge.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count one comparison and report it if the observed value differs from the expected one.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Drive one cycle of bus/start inputs across a single rising edge, then return them to idle.
  task automatic applyStimulus(input logic mw, input logic [31:0] adr, input logic [31:0] wd, input logic st);
    memWrite  = mw;
    dataAdr   = adr;
    writeData = wd;
    start     = st;
    @(negedge clock);
    memWrite  = 1'b0;
    dataAdr   = '0;
    writeData = '0;
    start     = 1'b0;
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Main directed sequence; each block mirrors one scenario from the test plan.
  initial begin
    checkCount = 0;
    failCount  = 0;
    reset      = 1'b1;
    start      = 1'b0;
    memWrite   = 1'b0;
    dataAdr    = '0;
    writeData  = '0;
    expAddrA   = 32'd100;
    expDataA   = 32'd25;
    expAddrB   = {32'd108, 32'd104, 32'd100};
    expDataB   = {32'd9, 32'd3, 32'd25};
`ifdef STORE_CHECKER_CAPTURE_EN
    expFailAddr = 32'd100;
    expFailData = 32'd24;
`else
    expFailAddr = 32'd0;
    expFailData = 32'd0;
`endif

    @(negedge clock);
    checkOutput("rst_state", stateA, 0);
    checkOutput("rst_done", doneA, 0);
    checkOutput("rst_pass", passA, 0);
    checkOutput("rst_fail", failA, 0);
    checkOutput("rst_cnts", {matchA, ignoreA, cycleA}, 0);
    checkOutput("rst_failaddr", failAddrA, 0);
    reset = 1'b0;
    @(negedge clock);

    // Scenario 1: ignored scratch store, then the matching store.
    applyStimulus(0, 0, 0, 1);
    checkOutput("s1_run", stateA, 1);
    checkOutput("s1_cycle0", cycleA, 0);
    applyStimulus(1, 96, 7, 0);
    checkOutput("s1_ignore", ignoreA, 1);
    checkOutput("s1_still_run", stateA, 1);
    checkOutput("s1_cycle1", cycleA, 1);
    applyStimulus(1, 100, 25, 0);
    checkOutput("s1_pass_state", stateA, 2);
    checkOutput("s1_pass", passA, 1);
    checkOutput("s1_done", doneA, 1);
    checkOutput("s1_match", matchA, 1);
    applyStimulus(1, 100, 24, 0);
    checkOutput("s6_sticky_state", stateA, 2);
    checkOutput("s6_sticky_cnts", {matchA, ignoreA, cycleA}, {16'd1, 16'd1, 16'd2});

    // Scenario 6b + 2: rerun from PASS, then a mismatching store.
    applyStimulus(0, 0, 0, 1);
    checkOutput("s6_rerun_state", stateA, 1);
    checkOutput("s6_rerun_cnts", {matchA, ignoreA, cycleA}, 0);
    applyStimulus(1, 100, 24, 0);
    checkOutput("s2_fail_state", stateA, 3);
    checkOutput("s2_fail", failA, 1);
    checkOutput("s2_pass", passA, 0);
    checkOutput("s2_match", matchA, 0);
    checkOutput("s2_fail_addr", failAddrA, expFailAddr);
    checkOutput("s2_fail_data", failDataA, expFailData);

    // Scenario 3: rerun from FAIL with no stores until the timeout expires.
    applyStimulus(0, 0, 0, 1);
    checkOutput("s3_run", stateA, 1);
    checkOutput("s3_fail_addr_clr", failAddrA, 0);
    for (int i = 0; i < 24; i++) applyStimulus(0, 0, 0, 0);
    checkOutput("s3_pre_state", stateA, 1);
    checkOutput("s3_pre_cycle", cycleA, 24);
    applyStimulus(0, 0, 0, 0);
    checkOutput("s3_timeout_state", stateA, 4);
    checkOutput("s3_timeout_fail", failA, 1);
    checkOutput("s3_timeout_cycle", cycleA, 24);
    applyStimulus(0, 0, 0, 0);
    checkOutput("s3_frozen_cycle", cycleA, 24);

    // Scenario 6a: reset in the middle of a run, then stores while idle.
    applyStimulus(0, 0, 0, 1);
    applyStimulus(1, 96, 7, 0);
    checkOutput("s6_mid_ignore", ignoreA, 1);
    pulseReset();
    checkOutput("s6_mid_state", stateA, 0);
    checkOutput("s6_mid_cnts", {matchA, ignoreA, cycleA}, 0);
    applyStimulus(1, 100, 25, 0);
    checkOutput("s6_idle_state", stateA, 0);
    checkOutput("s6_idle_match", matchA, 0);

    // Scenario 4: three-entry table, in order and then out of order.
    applyStimulus(0, 0, 0, 1);
    applyStimulus(1, 100, 25, 0);
    checkOutput("s4a_m1", matchB, 1);
    applyStimulus(1, 96, 1, 0);
    checkOutput("s4a_ign", ignoreB, 1);
    applyStimulus(1, 104, 3, 0);
    checkOutput("s4a_m2_state", {stateB, matchB}, {3'd1, 16'd2});
    applyStimulus(1, 108, 9, 0);
    checkOutput("s4a_pass_state", stateB, 2);
    checkOutput("s4a_match", matchB, 3);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(1, 104, 3, 0);
    checkOutput("s4b_fail_state", stateB, 3);
    checkOutput("s4b_match", matchB, 0);

    // Scenario 5: two-cycle timeout; expiry alone, store verdicts on the expiry edge.
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("s5_edge1", stateC, 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("s5_expire", stateC, 4);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(1, 100, 25, 0);
    checkOutput("s5_pass_beats_to", stateC, 2);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(1, 100, 24, 0);
    checkOutput("s5_fail_beats_to", stateC, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
